pwm_peripheral: RTL and testbench

- Consumes the five control registers written over SPI by the upstream SPI register block.
- Drives 16 general-purpose outputs, each either static or modulated by one shared 8-bit PWM waveform.
- Register map feeding this block: 0x00/0x01 output enables, 0x02/0x03 PWM-mode enables, 0x04 duty cycle.
- Runs on the system clock. Register inputs arrive already in this clock domain.

---
 rtl/pwm_peripheral.sv | 108 ++++++++++
 tb/tb_pwm_peripheral.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 general-purpose outputs, each either off, static high,
// or modulated by one shared 8-bit PWM waveform. The duty cycle is shadowed
// and updated only at the period wrap, so a mid-period write never causes a
// runt pulse. All outputs are registered.
module pwm_peripheral #(
  // System clocks per PWM tick; legal range 1..4095.
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PW = 12;
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_shadow;
  logic          tick;
  logic          wrap;
  logic          pwm_sig;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   out_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // tick marks the last clock of each prescaler cycle; wrap is the last
  // tick of a PWM period.
  assign tick = (prescaler == DIV_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Prescaler: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 12'd1;
    end
  end

  // Period counter: advances on every tick, free-running 255 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 8'h00;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Duty shadow and period strobe: sample the live duty register only at
  // the period wrap so the running period is never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow  <= 8'h00;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        duty_shadow <= pwm_duty_cycle;
      end
    end
  end

  // PWM compare: 0xFF is forced to a solid 100% high instead of 255/256.
  always_comb begin
    pwm_sig = 1'b0;
    if (duty_shadow == 8'hFF) begin
      pwm_sig = 1'b1;
    end else begin
      pwm_sig = (pwm_cnt < duty_shadow);
    end
  end

  // Per-pin select: disabled -> 0, static mode -> 1, PWM mode -> pwm_sig.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < 16; i++) begin
      if (!en_out[i]) begin
        out_next[i] = 1'b0;
      end else if (!en_pwm[i]) begin
        out_next[i] = 1'b1;
      end else begin
        out_next[i] = pwm_sig;
      end
    end
  end

  // Output register: enable changes reach the pins one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 16'h0000;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: table vectors, hand-written multi-cycle sequences and
// randomized segments, all checked against a cycle-count reference model.
module tb_pwm_peripheral;

  localparam int D      = 13;
  localparam int PERIOD = 256 * D;

  logic        clk;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pwm_peripheral #(.CLK_DIV(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed cycles since reset determine the position in
  // the period; the duty seen by a period is whatever was on the input in
  // the final clock of the previous period.
  int          m_c;
  logic [7:0]  m_shadow;
  logic [15:0] exp_out;
  logic        exp_ps;
  logic        chk_en = 1'b0;

  function automatic logic [15:0] model_out(int c, logic [7:0] shadow,
                                            logic [15:0] eo, logic [15:0] ep);
    int   pos;
    logic sig;
    pos = (c / D) % 256;
    sig = (shadow == 8'hFF) ? 1'b1 : (pos < int'(shadow));
    return eo & (~ep | {16{sig}});
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_c      <= 0;
      m_shadow <= 8'h00;
      exp_out  <= 16'h0000;
      exp_ps   <= 1'b0;
    end else begin
      exp_out <= model_out(m_c, m_shadow, en_out, en_pwm);
      exp_ps  <= ((m_c % PERIOD) == PERIOD - 1);
      if ((m_c % PERIOD) == PERIOD - 1) m_shadow <= duty;
      m_c <= m_c + 1;
    end
  end

  // Scoreboard: every negedge once enabled, DUT pins vs model.
  always @(negedge clk) begin
    if (chk_en) begin
      vec_cnt++;
      if (out !== exp_out || period_start !== exp_ps) begin
        miss_cnt++;
        $display("FAIL model t=%0t: out=%h ps=%b expected out=%h ps=%b",
                 $time, out, period_start, exp_out, exp_ps);
      end
    end
  end

  // Driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out = eo;
    en_pwm = ep;
    duty   = d;
  endtask

  // Wait for the period strobe, bounded; n = negedges elapsed.
  task automatic wait_ps(output int n);
    n = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk);
      n++;
      if (period_start) return;
    end
    miss_cnt++;
    vec_cnt++;
    $display("FAIL wait_ps: no period_start within %0d cycles", 2 * PERIOD);
  endtask

  // Advance n negedges, counting how often out[0] is high.
  task automatic window(input int n, output int highs, output int lows);
    highs = 0;
    lows  = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out[0]) highs++;
      else lows++;
    end
  endtask

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, h, l, h2, l2, ps_seen;

    // First period after reset runs with shadow 0, so PWM bits read 0.
    tbl[0] = '{eo: 16'h00FF, ep: 16'h0000, exp: 16'h00FF};
    tbl[1] = '{eo: 16'hA5A5, ep: 16'h0F0F, exp: 16'hA0A0};
    tbl[2] = '{eo: 16'hFFFF, ep: 16'hFFFF, exp: 16'h0000};
    tbl[3] = '{eo: 16'h0000, ep: 16'hFFFF, exp: 16'h0000};
    tbl[4] = '{eo: 16'h1234, ep: 16'h0204, exp: 16'h1030};

    // Reset with every input at 0xFF
    rst = 1'b1;
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);
    @(negedge clk);
    check("reset_out_1", 32'(out), 32'h0);
    check("reset_ps_1", 32'(period_start), 32'h0);
    @(negedge clk);
    check("reset_out_2", 32'(out), 32'h0);
    check("reset_ps_2", 32'(period_start), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Table vectors: applied at one negedge, checked at the next.
    for (int i = 0; i < 5; i++) begin
      set_in(tbl[i].eo, tbl[i].ep, 8'h00);
      @(negedge clk);
      check($sformatf("table_%0d", i), 32'(out), 32'(tbl[i].exp));
    end

    // 50% duty; first strobe lands exactly one period after release.
    set_in(16'hFFFF, 16'hFFFF, 8'h80);
    wait_ps(n);
    check("first_ps_latency", 32'(n), 32'(PERIOD - 5));
    window(PERIOD, h, l);
    check("duty50_high", 32'(h), 32'(128 * D));
    check("duty50_low", 32'(l), 32'(128 * D));
    check("duty50_period", 32'(period_start), 32'h1);

    // 100%: captured at the next wrap, then no low cycle for 3 periods.
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);
    window(PERIOD, h, l);
    window(3 * PERIOD, h, l);
    check("duty100_lows", 32'(l), 32'h0);

    // 0%: constant low for a full period.
    set_in(16'hFFFF, 16'hFFFF, 8'h00);
    window(PERIOD, h, l);
    window(PERIOD, h, l);
    check("duty0_highs", 32'(h), 32'h0);

    // Glitch-free update: 0x40 running, 0xC0 written at pwm_cnt 0x20.
    set_in(16'hFFFF, 16'hFFFF, 8'h40);
    window(PERIOD, h, l);
    window(32 * D, h, l);
    set_in(16'hFFFF, 16'hFFFF, 8'hC0);
    window(PERIOD - 32 * D, h2, l2);
    check("glitch_cur_high", 32'(h + h2), 32'(64 * D));
    window(PERIOD, h, l);
    check("glitch_next_high", 32'(h), 32'(192 * D));

    // Mixed enables, then reset at pwm_cnt 0x50.
    set_in(16'hA5A5, 16'h0F0F, 8'h80);
    window(PERIOD, h, l);
    window(80 * D, h, l);
    check("mixed_high_phase", 32'(out), 32'hA5A5);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out", 32'(out), 32'h0);
    check("midreset_ps", 32'(period_start), 32'h0);
    rst = 1'b0;
    ps_seen = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      if (k == 1) check("restart_static", 32'(out), 32'hA0A0);
      if (k < PERIOD && period_start) ps_seen++;
    end
    check("restart_early_ps", 32'(ps_seen), 32'h0);
    check("restart_period", 32'(period_start), 32'h1);

    // Randomized segments against the model.
    for (int s = 0; s < 10; s++) begin
      set_in(16'($urandom), 16'($urandom), 8'($urandom));
      if (s == 3) set_in(en_out, en_pwm, 8'hFF);
      if (s == 6) set_in(en_out, en_pwm, 8'h00);
      window(int'($urandom_range(300, 1500)), h, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
